seg_scan_rx: RTL and testbench
==============================

# seg_scan_rx

Receive-side counterpart of the `diglab` 8-digit seven-segment scan driver. It samples the multiplexed `which`/`seg`/`enable` scan bus and rebuilds the full 8-digit display image as a parallel frame. It also decodes each digit to a hex nibble and reports when the image has been stable for a programmable number of frames. It sits between the display driver and self-checking benches or on-chip monitors.

## Interface
- `DWELL`, 2: consecutive identical-bus cycles required before a digit is captured (1–255).
- `STABLE_FRAMES`, 3: consecutive identical frames required to raise `stable` (1–15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `which` in 3: digit position currently driven (0–7).
- `seg` in 8: segment pattern; bit7 = dp, bits6:0 = g..a; active-high.
- `enable` in 1: high means the current `which`/`seg` pair is valid.
- `frame` out 64: captured image; digit n is at `frame[8n+7:8n]`.
- `frame_valid` out 1: one-cycle pulse when `frame` updates.
- `frame_cnt` out 16: number of completed frames; wraps at 0xFFFF→0.
- `dup` out 1: one-cycle pulse when a position is recaptured before the frame completes.
- `stable` out 1: high after `STABLE_FRAMES` identical consecutive frames.
- `hex` out 32: decoded nibble per digit; digit n is at `hex[4n+3:4n]`.
- `hex_ok` out 8: bit n is set when digit n holds a recognised hex glyph.

## Operation
- Dwell counter:
  - Increments while `enable`=1 and `which`/`seg` equal the previous cycle's values.
  - Loads 1 on any change of `which` or `seg`, or on `enable` rising.
  - Clears to 0 while `enable`=0.
  - Saturates at `DWELL`.
- Capture happens on the cycle the dwell counter reaches exactly `DWELL`. That is one capture per dwell run, so a held digit is not recaptured.
  - `shadow[which]` ← `seg`.
  - `seen[which]` ← 1.
- `DWELL`=1: every enabled cycle whose bus differs from the previous cycle captures. An unchanged bus captures only on `enable` rising.
- If the position is already set in `seen` when captured: overwrite it (latest wins) and pulse `dup`.
- Frame complete when `seen` including the current capture equals 8'hFF. Then:
  - `frame` ← shadow with the current capture merged.
  - Pulse `frame_valid`.
  - `frame_cnt` ← `frame_cnt`+1.
  - Clear `seen`. A capture on the same cycle is part of the completed frame and does not pre-seed the next one.
- Stability counter (4 bits):
  - On `frame_valid`: if the new frame equals the previous `frame`, increment, saturating at `STABLE_FRAMES`; otherwise load 1.
  - `stable` = (counter ≥ `STABLE_FRAMES`).
  - The first frame after reset always loads 1.
- Hex decode is combinational from `frame[6:0]` of each digit; dp is ignored.
  - Glyph map: 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - Any other pattern gives nibble 0 and `hex_ok[n]`=0.

## Timing
- Reset values:
  - `frame`, `frame_cnt`, `hex`, `hex_ok` = 0.
  - `frame_valid`, `dup`, `stable` = 0.
  - `seen`, shadow, dwell counter, stability counter = 0.
- Latency: `frame_valid` and `frame` update on the clock edge ending the completing capture cycle, i.e. visible the cycle after the 8th digit's dwell is satisfied. `hex`/`hex_ok` follow `frame` in the same cycle.
- `frame_valid` and `dup` are single-cycle; both may assert together.
- `rst` mid-frame discards partial captures. The first post-reset frame needs all 8 positions again.
- `enable` low mid-dwell aborts that digit with no capture; `seen` is retained.
- Out-of-order `which` sequences are legal; completion depends only on `seen`.

## Configuration
- `SEG_SCAN_RX_HEXDEC_EN` defined: hex decoder is present as described.
- Undefined: decoder is not instantiated, and `hex` = 0 and `hex_ok` = 0 constantly. Frame, stability and count logic are unchanged.

## Test plan
- Reset held 2 cycles with `enable`=1 → all outputs 0, no capture; then scan 0–7 with seg=3F,06,5B,4F,66,6D,7D,07 at `DWELL`=2 → `frame_valid` pulse, `frame`=64'h077D6D664F5B063F, `hex`=32'h76543210, `hex_ok`=FF, `frame_cnt`=1.
- Repeat the identical scan 3× → `stable` rises on the 3rd `frame_valid`; one digit changed on the 4th scan → `stable` falls with that frame.
- Glitch: position 2 seg held 1 cycle only at `DWELL`=2 → no capture; frame is not completed until the position is held 2 cycles.
- Positions 0,1,1,2..7 → `dup` pulse on the second 1; the frame holds the latest position-1 value; a single `frame_valid`.
- `rst` after 5 positions, then 8 fresh positions → exactly one `frame_valid`, `frame_cnt`=1.
- Position 4 seg=0x00 → `hex_ok[4]`=0, `hex[19:16]`=0; with the macro undefined, `hex`=0 for all frames.

Source files
------------

// File: rtl/seg_scan_rx.sv
// seg_scan_rx
//
// Receive side of an 8-digit multiplexed seven-segment scan bus. Each digit
// is captured once its which/seg pair has been held for DWELL cycles, and
// the captures are assembled into a 64-bit display image. The module also
// reports recaptures of a position, counts completed frames and flags a
// display that has stayed unchanged for STABLE_FRAMES frames.
//
// Optional feature macro: SEG_SCAN_RX_HEXDEC_EN
//   defined   -> per-digit hex decoder drives hex/hex_ok from frame
//   undefined -> hex and hex_ok are tied to zero
//
// Parameters
//   DWELL          identical-bus cycles needed to capture a digit (1..255)
//   STABLE_FRAMES  identical consecutive frames needed for stable (1..15)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   which[2:0]   in   digit position on the bus
//   seg[7:0]     in   segment pattern, bit7 = dp, bits6:0 = g..a
//   enable       in   which/seg valid
//   frame[63:0]  out  captured image, digit n at frame[8n+7:8n]
//   frame_valid  out  one-cycle pulse when frame updates
//   frame_cnt    out  completed-frame count, wraps
//   dup          out  one-cycle pulse on recapture inside an open frame
//   stable       out  image identical for STABLE_FRAMES frames
//   hex[31:0]    out  decoded nibble per digit
//   hex_ok[7:0]  out  digit n holds a recognised hex glyph
module seg_scan_rx #(
    parameter int unsigned DWELL         = 2,
    parameter int unsigned STABLE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    input  logic        enable,
    output logic [63:0] frame,
    output logic        frame_valid,
    output logic [15:0] frame_cnt,
    output logic        dup,
    output logic        stable,
    output logic [31:0] hex,
    output logic [7:0]  hex_ok
);

    localparam logic [7:0] DWELL_L = 8'(DWELL);
    localparam logic [3:0] STAB_L  = 4'(STABLE_FRAMES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

    logic [2:0]      prev_which_q, prev_which_d;
    logic [7:0]      prev_seg_q, prev_seg_d;
    logic            prev_en_q, prev_en_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [7:0][7:0] shadow_q, shadow_d;
    logic [7:0]      seen_q, seen_d;
    logic [63:0]     frame_q, frame_d;
    logic            frame_valid_q, frame_valid_d;
    logic            dup_q, dup_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [3:0]      stab_q, stab_d;

    logic            bus_load;
    logic            capture;
    logic            complete;
    logic [7:0][7:0] shadow_cap;
    logic [7:0]      seen_cap;

    always_comb begin
        prev_which_d = which;
        prev_seg_d   = seg;
        prev_en_d    = enable;

        // A new dwell run starts on any bus change or on enable rising.
        bus_load = enable && (!prev_en_q || (which != prev_which_q) || (seg != prev_seg_q));

        if (!enable) begin
            dwell_d = 8'd0;
        end else if (bus_load) begin
            dwell_d = 8'd1;
        end else begin
            dwell_d = sat_inc8(dwell_q, DWELL_L);
        end

        // Capture only on the transition into DWELL; a counter already
        // saturated at DWELL means this run has been captured. With DWELL=1
        // every load is itself the transition.
        capture = (dwell_d == DWELL_L) && (bus_load || (dwell_q != DWELL_L));

        shadow_cap = shadow_q;
        seen_cap   = seen_q;
        if (capture) begin
            shadow_cap[which] = seg;
            seen_cap[which]   = 1'b1;
        end

        complete      = capture && (&seen_cap);
        dup_d         = capture && seen_q[which];
        frame_valid_d = complete;
        shadow_d      = shadow_cap;
        seen_d        = complete ? 8'd0 : seen_cap;
        frame_d       = frame_q;
        frame_cnt_d   = frame_cnt_q;
        stab_d        = stab_q;

        if (complete) begin
            frame_d     = shadow_cap;
            frame_cnt_d = frame_cnt_q + 16'd1;
            // stab_q == 0 only before the first frame after reset, so the
            // first frame always loads 1 even if the image is all zeros.
            if ((stab_q != 4'd0) && (shadow_cap == frame_q)) begin
                stab_d = sat_inc4(stab_q, STAB_L);
            end else begin
                stab_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_which_q  <= 3'd0;
            prev_seg_q    <= 8'd0;
            prev_en_q     <= 1'b0;
            dwell_q       <= 8'd0;
            shadow_q      <= '0;
            seen_q        <= 8'd0;
            frame_q       <= 64'd0;
            frame_valid_q <= 1'b0;
            dup_q         <= 1'b0;
            frame_cnt_q   <= 16'd0;
            stab_q        <= 4'd0;
        end else begin
            prev_which_q  <= prev_which_d;
            prev_seg_q    <= prev_seg_d;
            prev_en_q     <= prev_en_d;
            dwell_q       <= dwell_d;
            shadow_q      <= shadow_d;
            seen_q        <= seen_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            dup_q         <= dup_d;
            frame_cnt_q   <= frame_cnt_d;
            stab_q        <= stab_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign dup         = dup_q;
    assign stable      = (stab_q >= STAB_L);

`ifdef SEG_SCAN_RX_HEXDEC_EN
    // Returns {ok, nibble}; dp is not part of the glyph.
    function automatic logic [4:0] hex_decode(input logic [6:0] g);
        case (g)
            7'h3F:   return 5'h10;
            7'h06:   return 5'h11;
            7'h5B:   return 5'h12;
            7'h4F:   return 5'h13;
            7'h66:   return 5'h14;
            7'h6D:   return 5'h15;
            7'h7D:   return 5'h16;
            7'h07:   return 5'h17;
            7'h7F:   return 5'h18;
            7'h6F:   return 5'h19;
            7'h77:   return 5'h1A;
            7'h7C:   return 5'h1B;
            7'h39:   return 5'h1C;
            7'h5E:   return 5'h1D;
            7'h79:   return 5'h1E;
            7'h71:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        hex    = 32'd0;
        hex_ok = 8'd0;
        for (int n = 0; n < 8; n++) begin
            {hex_ok[n], hex[4*n +: 4]} = hex_decode(frame_q[8*n +: 7]);
        end
    end
`else
    assign hex    = 32'd0;
    assign hex_ok = 8'd0;
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: directed scenarios from the display scan use cases
// plus a randomized scan, all compared against a behavioural model that
// tracks run lengths, captured digits and completed frames directly.
module tb_seg_scan_rx;

    localparam int DW = 2;
    localparam int SF = 3;
`ifdef SEG_SCAN_RX_HEXDEC_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [63:0] IMG = 64'h077D6D664F5B063F;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic        enable;
    logic [63:0] frame;
    logic        frame_valid;
    logic [15:0] frame_cnt;
    logic        dup;
    logic        stable;
    logic [31:0] hex;
    logic [7:0]  hex_ok;

    seg_scan_rx #(.DWELL(DW), .STABLE_FRAMES(SF)) dut (
        .clk(clk), .rst(rst), .which(which), .seg(seg), .enable(enable),
        .frame(frame), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
        .dup(dup), .stable(stable), .hex(hex), .hex_ok(hex_ok)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int          run;
    bit          m_pen;
    logic [2:0]  m_pw;
    logic [7:0]  m_ps;
    logic [7:0]  m_shadow [8];
    bit          m_seen [8];
    logic [63:0] m_frame;
    logic [15:0] m_cnt;
    int          m_stab;
    bit          exp_fv, exp_dup;
    int          pulse_err = 0;
    int          obs_fv = 0;
    int          obs_dup = 0;

    // Returns {hex_ok, hex} expected for an image.
    function automatic logic [39:0] ref_hex(input logic [63:0] f);
        logic [39:0] r = '0;
        for (int n = 0; n < 8; n++) begin
            for (int g = 0; g < 16; g++) begin
                if (f[8*n +: 7] == GLYPH[g]) begin
                    r[4*n +: 4] = 4'(g);
                    r[32+n]     = 1'b1;
                end
            end
        end
        return HEX_EN ? r : 40'd0;
    endfunction

    task automatic model_clear();
        run = 0; m_pen = 0; m_pw = 0; m_ps = 0;
        for (int n = 0; n < 8; n++) begin
            m_shadow[n] = 8'd0;
            m_seen[n]   = 0;
        end
        m_frame = 64'd0; m_cnt = 16'd0; m_stab = 0;
        exp_fv = 0; exp_dup = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; which = 3'd3; seg = 8'h3F;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One bus cycle: update the model with the inputs, clock, observe pulses.
    task automatic drive(input logic [2:0] w, input logic [7:0] s, input logic e);
        bit all_seen;
        logic [63:0] nf;
        which = w; seg = s; enable = e;
        if (!e) run = 0;
        else if (m_pen && w == m_pw && s == m_ps) run++;
        else run = 1;
        exp_fv = 0; exp_dup = 0;
        if (e && run == DW) begin
            if (m_seen[w]) exp_dup = 1;
            m_shadow[w] = s;
            m_seen[w]   = 1;
            all_seen = 1;
            for (int n = 0; n < 8; n++) all_seen &= m_seen[n];
            if (all_seen) begin
                for (int n = 0; n < 8; n++) begin
                    nf[8*n +: 8] = m_shadow[n];
                    m_seen[n] = 0;
                end
                if (m_stab > 0 && nf == m_frame) m_stab = (m_stab + 1 > SF) ? SF : m_stab + 1;
                else m_stab = 1;
                m_frame = nf;
                m_cnt++;
                exp_fv = 1;
            end
        end
        m_pen = e; m_pw = w; m_ps = s;
        @(posedge clk);
        #1;
        if (frame_valid) obs_fv++;
        if (dup) obs_dup++;
        if (frame_valid !== exp_fv || dup !== exp_dup) pulse_err++;
    endtask

    task automatic hold(input logic [2:0] w, input logic [7:0] s, input int cycles);
        for (int i = 0; i < cycles; i++) drive(w, s, 1'b1);
    endtask

    task automatic scan_frame(input logic [63:0] f);
        for (int n = 0; n < 8; n++) hold(3'(n), f[8*n +: 8], DW);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (frame !== 64'd0 || frame_cnt !== 16'd0) $display("FAIL reset_frame frame=%h cnt=%0d want 0", frame, frame_cnt);
        else n_pass++;
        n_total++;
        if (frame_valid !== 1'b0 || dup !== 1'b0 || stable !== 1'b0) $display("FAIL reset_flags fv=%b dup=%b stable=%b want 0", frame_valid, dup, stable);
        else n_pass++;
        n_total++;
        if (hex !== 32'd0 || hex_ok !== 8'd0) $display("FAIL reset_hex hex=%h ok=%h want 0", hex, hex_ok);
        else n_pass++;
    endtask

    task automatic test_basic();
        scan_frame(IMG);
        n_total++;
        if (frame_valid !== 1'b1) $display("FAIL basic_fv got %b want 1", frame_valid);
        else n_pass++;
        n_total++;
        if (frame !== IMG) $display("FAIL basic_frame got %h want %h", frame, IMG);
        else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd1) $display("FAIL basic_cnt got %0d want 1", frame_cnt);
        else n_pass++;
        n_total++;
        if (hex !== (HEX_EN ? 32'h76543210 : 32'd0) || hex_ok !== (HEX_EN ? 8'hFF : 8'h00))
            $display("FAIL basic_hex got %h/%h want %h/%h", hex, hex_ok,
                     HEX_EN ? 32'h76543210 : 32'd0, HEX_EN ? 8'hFF : 8'h00);
        else n_pass++;
        drive(3'd0, 8'h00, 1'b0);
        n_total++;
        if (frame_valid !== 1'b0) $display("FAIL basic_fv_single got %b want 0", frame_valid);
        else n_pass++;
    endtask

    task automatic test_stable();
        logic [63:0] alt;
        scan_frame(IMG);
        n_total++;
        if (stable !== 1'b0) $display("FAIL stable_2nd got %b want 0", stable);
        else n_pass++;
        scan_frame(IMG);
        n_total++;
        if (stable !== 1'b1 || frame_valid !== 1'b1) $display("FAIL stable_3rd stable=%b fv=%b want 1/1", stable, frame_valid);
        else n_pass++;
        alt = IMG;
        alt[23:16] = 8'h7F;
        scan_frame(alt);
        n_total++;
        if (stable !== 1'b0 || frame !== alt) $display("FAIL stable_change stable=%b frame=%h want 0/%h", stable, frame, alt);
        else n_pass++;
        n_total++;
        if (stable !== (m_stab >= SF) || frame_cnt !== m_cnt) $display("FAIL stable_model stable=%b cnt=%0d want %b/%0d", stable, frame_cnt, m_stab >= SF, m_cnt);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int fv0;
        drive(3'd0, 8'h00, 1'b0);
        fv0 = obs_fv;
        hold(3'd0, 8'h3F, DW);
        hold(3'd1, 8'h06, DW);
        hold(3'd2, 8'h5B, 1);
        for (int n = 3; n < 8; n++) hold(3'(n), IMG[8*n +: 8], DW);
        n_total++;
        if (obs_fv !== fv0) $display("FAIL glitch_nocap frames=%0d want %0d", obs_fv - fv0, 0);
        else n_pass++;
        hold(3'd2, 8'h5B, DW);
        n_total++;
        if (frame_valid !== 1'b1 || frame !== IMG) $display("FAIL glitch_done fv=%b frame=%h want 1/%h", frame_valid, frame, IMG);
        else n_pass++;
    endtask

    task automatic test_dup();
        int fv0, dup0;
        logic [63:0] want;
        fv0 = obs_fv; dup0 = obs_dup;
        hold(3'd0, 8'h3F, DW);
        hold(3'd1, 8'h06, DW);
        hold(3'd1, 8'h77, DW);
        n_total++;
        if (dup !== 1'b1) $display("FAIL dup_pulse got %b want 1", dup);
        else n_pass++;
        for (int n = 2; n < 8; n++) hold(3'(n), IMG[8*n +: 8], DW);
        want = IMG;
        want[15:8] = 8'h77;
        n_total++;
        if (frame !== want || (obs_fv - fv0) !== 1 || (obs_dup - dup0) !== 1)
            $display("FAIL dup_frame frame=%h fv=%0d dup=%0d want %h/1/1", frame, obs_fv - fv0, obs_dup - dup0, want);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int fv0;
        for (int n = 0; n < 5; n++) hold(3'(n), IMG[8*n +: 8], DW);
        do_reset();
        fv0 = obs_fv;
        scan_frame(IMG);
        n_total++;
        if (frame_cnt !== 16'd1 || (obs_fv - fv0) !== 1) $display("FAIL rstmid cnt=%0d fv=%0d want 1/1", frame_cnt, obs_fv - fv0);
        else n_pass++;
    endtask

    task automatic test_hex_bad();
        logic [63:0] img2;
        logic [39:0] r;
        img2 = IMG;
        img2[39:32] = 8'h00;
        scan_frame(img2);
        r = ref_hex(img2);
        n_total++;
        if (hex_ok[4] !== (HEX_EN ? 1'b0 : 1'b0) || hex[19:16] !== 4'd0 || {hex_ok, hex} !== r)
            $display("FAIL hex_bad got %h/%h want %h/%h", hex_ok, hex, r[39:32], r[31:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [39:0] r;
        for (int k = 0; k < 300; k++) begin
            logic [2:0] w;
            logic [7:0] s;
            logic       e;
            w = 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {1'($urandom), GLYPH[$urandom_range(0, 15)]};
            e = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) drive(w, s, e);
        end
        r = ref_hex(m_frame);
        n_total++;
        if (frame !== m_frame || frame_cnt !== m_cnt) $display("FAIL rand_frame got %h/%0d want %h/%0d", frame, frame_cnt, m_frame, m_cnt);
        else n_pass++;
        n_total++;
        if (stable !== (m_stab >= SF)) $display("FAIL rand_stable got %b want %b", stable, m_stab >= SF);
        else n_pass++;
        n_total++;
        if ({hex_ok, hex} !== r) $display("FAIL rand_hex got %h/%h want %h/%h", hex_ok, hex, r[39:32], r[31:0]);
        else n_pass++;
        n_total++;
        if (pulse_err !== 0) $display("FAIL pulse_timing errors=%0d want 0", pulse_err);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; which = 3'd0; seg = 8'd0;
        model_clear();
        test_reset();
        test_basic();
        test_stable();
        test_glitch();
        test_dup();
        test_reset_mid();
        test_hex_bad();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
